// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the pin-label UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    typedef logic [3:0][7:0] label_t;

    function automatic int uart_bit_cyc(input int clk_mhz, input int rate);
        return (clk_mhz * 1000000) / rate;
    endfunction

    function automatic logic byte_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 byte receiver: 2-flop synchroniser, byte FSM, frame check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 25,
    parameter int UART_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       line_idle,
    output logic       rx_fall
);

    localparam int c_BIT_CYC = uart_bit_cyc(CLK_FRE, UART_RATE);
    localparam int c_HALF    = c_BIT_CYC / 2;
    localparam int c_CW      = $clog2(c_BIT_CYC);
    localparam logic [c_CW-1:0] c_HALF_END = c_CW'(c_HALF - 1);
    localparam logic [c_CW-1:0] c_BIT_END  = c_CW'(c_BIT_CYC - 1);

    logic [1:0]      r_sync;
    logic            r_rx_prev;
    logic            w_rx;
    logic            w_fall;
    rx_state_t       r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;

    assign w_rx      = r_sync[1];
    assign w_fall    = r_rx_prev & ~w_rx;
    assign rx_fall   = w_fall;
    assign line_idle = (r_state == IDLE) & w_rx;

    // Synchroniser resets to the idle level so release never fakes a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], uart_rx};
            r_rx_prev <= r_sync[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    if (r_cnt == c_HALF_END) begin
                        r_cnt <= '0;
                        if (!w_rx) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == c_BIT_END) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == c_BIT_END) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            rx_data  <= r_shift;
                            rx_valid <= 1'b1;
                            r_state  <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (w_rx) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_label_rx.sv
// ============================================================================
// Module      : uart_label_rx
// Description : UART receiver grouping 4 bytes into an ASCII pin label, with
//               idle-gap realignment. Optional macro LABEL_ASCII_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_label_rx
    import uart_pkg::*;
#(
    parameter int CLK_FRE    = 25,
    parameter int UART_RATE  = 115200,
    parameter int IDLE_BYTES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output label_t     label,
    output logic       label_valid,
    output logic       frame_err,
    output logic       label_err
);

    localparam int c_BIT_CYC  = uart_bit_cyc(CLK_FRE, UART_RATE);
    localparam int c_IDLE_LIM = IDLE_BYTES * 10 * c_BIT_CYC;
    localparam int c_IW       = $clog2(c_IDLE_LIM + 1);
    localparam logic [c_IW-1:0] c_IDLE_END = c_IW'(c_IDLE_LIM);
    localparam logic [c_IW-1:0] c_IDLE_PRE = c_IW'(c_IDLE_LIM - 1);

    logic            w_line_idle;
    logic            w_rx_fall;
    logic            w_timeout;
    logic [c_IW-1:0] r_idle_cnt;
    logic [1:0]      r_byte_cnt;
    logic [2:0][7:0] r_buf;

    uart_rx_byte #(
        .CLK_FRE   (CLK_FRE),
        .UART_RATE (UART_RATE)
    ) u_rx_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .line_idle (w_line_idle),
        .rx_fall   (w_rx_fall)
    );

    // Timeout fires once on the cycle the counter reaches its limit, then saturates.
    assign w_timeout = w_line_idle & ~w_rx_fall & (r_idle_cnt == c_IDLE_PRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (w_rx_fall) begin
            r_idle_cnt <= '0;
        end else if (w_line_idle && (r_idle_cnt != c_IDLE_END)) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // The fourth byte goes straight into label; only the first three are buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt  <= '0;
            r_buf       <= '0;
            label       <= '0;
            label_valid <= 1'b0;
        end else begin
            label_valid <= 1'b0;
            if (rx_valid) begin
                if (r_byte_cnt == 2'd3) begin
                    r_byte_cnt  <= '0;
                    label       <= {r_buf, rx_data};
                    label_valid <= 1'b1;
                end else begin
                    r_buf[2'd2 - r_byte_cnt] <= rx_data;
                    r_byte_cnt               <= r_byte_cnt + 1'b1;
                end
            end else if (frame_err || w_timeout) begin
                r_byte_cnt <= '0;
            end
        end
    end

`ifdef LABEL_ASCII_CHECK_EN
    logic w_non_print;

    assign w_non_print = ~(byte_printable(r_buf[2]) & byte_printable(r_buf[1]) &
                           byte_printable(r_buf[0]) & byte_printable(rx_data));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            label_err <= 1'b0;
        end else begin
            label_err <= rx_valid & (r_byte_cnt == 2'd3) & w_non_print;
        end
    end
`else
    assign label_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_label_rx.sv
// ============================================================================
// Module      : tb_uart_label_rx
// Description : Directed self-checking bench for uart_label_rx at 25 MHz/115200.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_label_rx;

    localparam int c_BIT = 217;  // 25e6 / 115200, truncated

    logic        clk;
    logic        rst_n;
    logic        uart_rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [3:0][7:0] label;
    logic        label_valid;
    logic        frame_err;
    logic        label_err;

    int          n_checks;
    int          n_fail;
    int          cyc;
    int          lat_start;
    int          lat_got;
    int          n_ferr;
    logic [7:0]  q_rx[$];
    logic [31:0] q_lbl[$];
    logic        q_lerr[$];

    uart_label_rx #(
        .CLK_FRE    (25),
        .UART_RATE  (115200),
        .IDLE_BYTES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rx     (uart_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .label       (label),
        .label_valid (label_valid),
        .frame_err   (frame_err),
        .label_err   (label_err)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid) begin
            q_rx.push_back(rx_data);
            if (lat_got < 0) lat_got = cyc - lat_start;
        end
        if (label_valid) begin
            q_lbl.push_back(label);
            q_lerr.push_back(label_err);
        end
        if (frame_err) n_ferr++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        q_rx.delete();
        q_lbl.delete();
        q_lerr.delete();
        n_ferr = 0;
    endtask

    task automatic drive_bit(input logic v);
        uart_rx = v;
        repeat (c_BIT) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        uart_rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rx_data"},     32'(rx_data),     32'h0);
        check({tag, "_rx_valid"},    32'(rx_valid),    32'h0);
        check({tag, "_label"},       label,            32'h0);
        check({tag, "_label_valid"}, 32'(label_valid), 32'h0);
        check({tag, "_frame_err"},   32'(frame_err),   32'h0);
        check({tag, "_label_err"},   32'(label_err),   32'h0);
    endtask

    function automatic logic [31:0] lbl_at(input int i);
        return (q_lbl.size() > i) ? q_lbl[i] : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] rx_at(input int i);
        return (q_rx.size() > i) ? 32'(q_rx[i]) : 32'hxxxxxxxx;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        lat_got  = 0;
        n_ferr   = 0;
        rst_n    = 1'b0;
        uart_rx  = 1'b1;
        repeat (5) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Basic label "  R2" plus start-to-rx_valid latency
        clear_mon();
        lat_start = cyc;
        lat_got   = -1;
        send_word(32'h20205232);
        repeat (10) @(negedge clk);
        check("t1_rx_count", q_rx.size(), 4);
        check("t1_rx0", rx_at(0), 32'h20);
        check("t1_rx1", rx_at(1), 32'h20);
        check("t1_rx2", rx_at(2), 32'h52);
        check("t1_rx3", rx_at(3), 32'h32);
        check("t1_latency", lat_got, 2064);  // 2 + 108 + 9*217 + 1
        check("t1_lbl_count", q_lbl.size(), 1);
        check("t1_label", lbl_at(0), 32'h20205232);
        check("t1_label_err", (q_lerr.size() > 0) ? 32'(q_lerr[0]) : 32'hx, 32'h0);

        // Lone fragment dropped by idle timeout
        clear_mon();
        send_byte(8'h41, 1'b1);
        repeat (3 * 10 * c_BIT) @(negedge clk);
        send_word(32'h20414231);
        repeat (10) @(negedge clk);
        check("t2_lbl_count", q_lbl.size(), 1);
        check("t2_label", lbl_at(0), 32'h20414231);

        // Frame error after one good byte must realign the label
        clear_mon();
        send_byte(8'h58, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (10) @(negedge clk);
        check("t3_frame_err", n_ferr, 1);
        check("t3_rx_count", q_rx.size(), 1);
        repeat (c_BIT) @(negedge clk);
        send_word(32'h20205036);
        repeat (10) @(negedge clk);
        check("t3_lbl_count", q_lbl.size(), 1);
        check("t3_label", lbl_at(0), 32'h20205036);

        // 2 us low glitch, shorter than half a bit
        clear_mon();
        uart_rx = 1'b0;
        repeat (50) @(negedge clk);
        uart_rx = 1'b1;
        repeat (400) @(negedge clk);
        check("t4_rx_count", q_rx.size(), 0);
        check("t4_frame_err", n_ferr, 0);

        // Zero-gap stream "AB20AA21"
        clear_mon();
        send_word(32'h41423230);
        send_word(32'h41413231);
        repeat (10) @(negedge clk);
        check("t5_rx_count", q_rx.size(), 8);
        check("t5_lbl_count", q_lbl.size(), 2);
        check("t5_label0", lbl_at(0), 32'h41423230);
        check("t5_label1", lbl_at(1), 32'h41413231);
        check("t5_label_hold", label, 32'h41413231);

        // Reset during bit 4 of the third byte
        clear_mon();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        uart_rx = 1'b1;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check_zero("t6_in_reset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        clear_mon();
        send_word(32'h20573139);
        repeat (10) @(negedge clk);
        check("t6_lbl_count", q_lbl.size(), 1);
        check("t6_label", lbl_at(0), 32'h20573139);

`ifdef LABEL_ASCII_CHECK_EN
        clear_mon();
        send_word(32'h01202020);
        repeat (10) @(negedge clk);
        check("t7_label", lbl_at(0), 32'h01202020);
        check("t7_label_err", (q_lerr.size() > 0) ? 32'(q_lerr[0]) : 32'hx, 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_label_rx.md
Name: uart_label_rx

Overview:
- UART receiver and label assembler for the pin-label UART stream.
- Samples one 8N1 line, recovers bytes, and groups every 4 consecutive bytes into a 32-bit ASCII pin label such as "  R2".
- Used on the bench or capture side to decode one `uart_tx` pin of the all-IO test and report which package pin is wired to it.
- Resynchronises to label boundaries using line-idle gaps.

Parameters:
- CLK_FRE, 25, system clock in MHz.
- UART_RATE, 115200, baud rate.
- IDLE_BYTES, 2, idle time that resets label alignment, in byte times (10 bits each).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- uart_rx  input  1  serial line; idles high; asynchronous to clk.
- rx_data  output  8  last received byte.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- label  output  [3:0][7:0]  assembled label; [3] is the first byte received.
- label_valid  output  1  one-cycle pulse when label updates.
- frame_err  output  1  one-cycle pulse on bad stop bit.
- label_err  output  1  one-cycle pulse alongside label_valid when the label is non-printable (see Optional Feature).

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: all outputs 0; label = 32'h0; FSM in IDLE; byte_cnt = 0; idle counter = 0.
- Reset mid-frame aborts immediately; the partial byte and label are discarded.
- Timing constants: BIT_CYC = CLK_FRE*1_000_000/UART_RATE, integer division (217 at defaults); HALF = BIT_CYC/2.
- Bit counter width: $clog2(BIT_CYC).
- Synchroniser: uart_rx passes through 2 flops before use. A falling edge is detected on the synchronised signal.
- Byte FSM states and transitions:
  - IDLE: on falling edge, go to START with counter cleared.
  - START: at count HALF-1, resample. If 0, go to DATA (counter cleared, bit index 0). If 1 (glitch), return to IDLE with no outputs.
  - DATA: sample every BIT_CYC cycles, LSB first, into a shift register. After bit 7, go to STOP.
  - STOP: sample after BIT_CYC cycles.
    - Sample is 1: rx_data <= byte and rx_valid pulses on the next clk edge; return to IDLE.
    - Sample is 0: frame_err pulses, no rx_valid; go to WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronised line is 1, then go to IDLE.
- End-to-end latency: falling edge on uart_rx to rx_valid = 2 (sync) + HALF + 9*BIT_CYC + 1 cycles.
- Label assembly:
  - On rx_valid, store the byte into buf[3-byte_cnt].
  - byte_cnt 0..2: increment.
  - byte_cnt 3: byte_cnt <= 0; label <= {buf[3:1], byte}; label_valid pulses one cycle after that rx_valid.
- label holds its value until the next complete label.
- Idle resync:
  - idle counter increments while the FSM is in IDLE and the line is high.
  - It clears on any falling edge.
  - On reaching IDLE_BYTES*10*BIT_CYC, byte_cnt <= 0; the counter saturates with no repeat effect.
- frame_err also clears byte_cnt.
- Simultaneous events:
  - Idle-timeout and rx_valid cannot coincide, because rx_valid implies recent activity.
  - If they do, rx_valid wins and the byte is counted.
- Back-to-back bytes with zero inter-frame gap (a stop bit followed directly by a start bit) must be received without loss.

Optional Feature:
- Macro: LABEL_ASCII_CHECK_EN.
- Defined: when label_valid pulses, label_err pulses the same cycle if any byte is outside 0x20..0x7E. label still updates.
- Undefined: label_err is tied to 0 and no compare logic is built.

Decomposition:
- Package uart_pkg:
  - function uart_bit_cyc(clk_mhz, rate).
  - typedef enum of rx states {IDLE, START, DATA, STOP, WAIT_HIGH}.
  - typedef logic [3:0][7:0] label_t.
- Sub-module uart_rx_byte:
  - Contains synchroniser, byte FSM, rx_data, rx_valid, frame_err and the idle flag.
  - uart_label_rx wraps it and adds byte_cnt, buffer, idle timeout and the ASCII check.

Test Plan:
1. Send bytes 0x20,0x20,0x52,0x32 at 115200 with a 25 MHz clk:
   - 4 rx_valid pulses with the matching rx_data.
   - Then label_valid with label = 32'h20205232 ("  R2"), label_err = 0.
2. Send a 1-byte 0x41, idle 3 byte times, then " AB1":
   - label = 32'h20414231, not the 0x41 fragment.
3. Send 0x55 with the stop bit driven 0:
   - frame_err pulses once, no rx_valid, byte_cnt resets.
   - Next clean "  P6" decodes to 32'h20205036.
4. Drive a 2 µs low glitch on uart_rx (below HALF = 108 cycles at 40 ns):
   - No rx_valid, no frame_err, FSM back in IDLE.
5. Stream "AB20AA21" back-to-back with zero gaps:
   - Two label_valid pulses: 32'h41423230, then 32'h41413231.
6. Assert rst_n low during bit 4 of the third byte, release, then send " W19":
   - All outputs 0 during reset; label = 32'h20573139.
   - With LABEL_ASCII_CHECK_EN defined, sending 0x01,0x20,0x20,0x20 gives label_err = 1 in the label_valid cycle.
